// File: rtl/led_code_encoder.sv
// One-hot button/LED-select encoder: synchronises and debounces three raw inputs,
// then delivers one 2-bit code per press over a valid/ready handshake.
module led_code_encoder #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       btn,
    output logic [1:0]       code,
    output logic             code_err,
    output logic             code_valid,
    input  logic             code_ready,
    output logic             busy,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OUT  = 2'd1,
        HOLD = 2'd2
    } state_t;

    logic [2:0]       s1_reg;
    logic [2:0]       s2_reg;
    logic [DEB_W-1:0] stable_cnt_reg;
    logic [2:0]       deb_vec_reg;

    state_t           state_reg;
    logic [1:0]       code_reg;
    logic             code_err_reg;
    logic             code_valid_reg;
    logic             busy_reg;
    logic [CNT_W-1:0] event_cnt_reg;

    logic [1:0]       enc_code;
    logic             enc_err;

    // Two-flop synchroniser on all three inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= btn;
            s2_reg <= s1_reg;
        end
    end

    // s1 is the value s2 takes at this edge, so s1 != s2 means s2 is about to change.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_cnt_reg <= '0;
            deb_vec_reg    <= '0;
        end else if (s1_reg != s2_reg) begin
            stable_cnt_reg <= '0;
        end else if (stable_cnt_reg != DEB_LAST) begin
            stable_cnt_reg <= stable_cnt_reg + 1'b1;
        end else begin
            deb_vec_reg <= s2_reg;
        end
    end

    always_comb begin
        enc_code = 2'b00;
        enc_err  = 1'b0;
        case (deb_vec_reg)
            3'b001:  enc_code = 2'b01;
            3'b010:  enc_code = 2'b10;
            3'b100:  enc_code = 2'b11;
            3'b000:  enc_err  = 1'b0;
            default: enc_err  = 1'b1;
        endcase
    end

    // A press is presented in OUT until taken, then HOLD waits for a debounced release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            code_reg       <= 2'b00;
            code_err_reg   <= 1'b0;
            code_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            event_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (deb_vec_reg != 3'b000) begin
                        code_reg       <= enc_code;
                        code_err_reg   <= enc_err;
                        code_valid_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                        state_reg      <= OUT;
                    end
                end
                OUT: begin
                    if (code_ready) begin
                        code_valid_reg <= 1'b0;
                        event_cnt_reg  <= event_cnt_reg + 1'b1;
                        state_reg      <= HOLD;
                    end
                end
                HOLD: begin
                    if (deb_vec_reg == 3'b000) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    code_valid_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                    state_reg      <= IDLE;
                end
            endcase
        end
    end

    assign code       = code_reg;
    assign code_err   = code_err_reg;
    assign code_valid = code_valid_reg;
    assign busy       = busy_reg;
    assign event_cnt  = event_cnt_reg;

endmodule

// File: tb/tb_led_code_encoder.sv
// Scoreboard bench for led_code_encoder: presses push expected codes, a monitor
// pops and compares on every valid/ready handshake.
module tb_led_code_encoder;

    localparam int DEB = 4;
    localparam int CW  = 8;

    typedef struct packed {
        logic [1:0]    code;
        logic          err;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [2:0]    btn;
    logic [1:0]    code;
    logic          code_err;
    logic          code_valid;
    logic          code_ready;
    logic          busy;
    logic [CW-1:0] event_cnt;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   exp_cnt    = 0;
    int   ready_mode = 0;

    led_code_encoder #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .btn(btn), .code(code), .code_err(code_err),
        .code_valid(code_valid), .code_ready(code_ready), .busy(busy),
        .event_cnt(event_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a one-hot vector with its set bit at position i maps to code i+1.
    task automatic push_exp(input logic [2:0] v);
        exp_t e;
        int   ones;
        ones    = $countones(v);
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        e.err   = (ones != 1);
        e.code  = (ones == 1) ? 2'($clog2(int'(v)) + 1) : 2'd0;
        e.cnt   = CW'(exp_cnt);
        sb.push_back(e);
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("handshake_wait", 32'(sb.size()), 32'd0);
        if (sb.size() != 0) sb.delete();
        tick();
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!code_valid && n < budget) begin
            tick();
            n++;
        end
        chk("valid_wait", 32'(code_valid), 32'd1);
    endtask

    initial begin
        code_ready = 1'b0;
        forever begin
            tick();
            case (ready_mode)
                0:       code_ready = 1'b0;
                1:       code_ready = 1'b1;
                default: code_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: a handshake seen at a falling edge completes at the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && code_valid && code_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {29'd0, code_err, code}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("code", 32'(code), 32'(e.code));
                    chk("code_err", 32'(code_err), 32'(e.err));
                    @(posedge clk);
                    #1;
                    chk("event_cnt", 32'(event_cnt), 32'(e.cnt));
                    chk("valid_drop", 32'(code_valid), 32'd0);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] v;
        int         len;
        bit         short_p;

        // Reset and idle
        rst = 1'b1;
        btn = 3'b000;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_err", 32'(code_err), 32'd0);
        chk("rst_valid", 32'(code_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(event_cnt), 32'd0);
        repeat (20) tick();
        chk("idle_valid", 32'(code_valid), 32'd0);
        chk("idle_cnt", 32'(event_cnt), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Latency and single-cycle valid with ready held high
        ready_mode = 1;
        repeat (2) tick();
        push_exp(3'b010);
        btn = 3'b010;
        repeat (DEB + 2) tick();
        chk("latency_early", 32'(code_valid), 32'd0);
        tick();
        chk("latency_rise", 32'(code_valid), 32'd1);
        chk("busy_out", 32'(busy), 32'd1);
        tick();
        chk("one_cycle_valid", 32'(code_valid), 32'd0);
        repeat (5) tick();
        chk("no_repeat", 32'(code_valid), 32'd0);
        chk("busy_hold", 32'(busy), 32'd1);
        btn = 3'b000;
        repeat (DEB + 4) tick();
        chk("busy_release", 32'(busy), 32'd0);
        push_exp(3'b100);
        btn = 3'b100;
        wait_empty(50);
        btn = 3'b000;
        repeat (DEB + 4) tick();

        // Back-pressure: code held while ready is low
        ready_mode = 0;
        repeat (2) tick();
        push_exp(3'b001);
        btn = 3'b001;
        wait_valid(50);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", 32'(code_valid), 32'd1);
            chk("hold_code", 32'(code), 32'd1);
        end
        ready_mode = 1;
        wait_empty(20);
        repeat (4) tick();
        chk("bp_single", 32'(code_valid), 32'd0);
        chk("bp_hold_busy", 32'(busy), 32'd1);
        btn = 3'b000;
        repeat (DEB + 4) tick();
        chk("bp_release", 32'(busy), 32'd0);

        // Reset while a code is pending
        ready_mode = 0;
        repeat (2) tick();
        btn = 3'b100;
        push_exp(3'b100);
        wait_valid(50);
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(code_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cnt", 32'(event_cnt), 32'd0);
        chk("midrst_code", {29'd0, code_err, code}, 32'd0);
        sb.delete();
        exp_cnt = 0;
        tick();
        rst = 1'b0;
        push_exp(3'b100);
        ready_mode = 1;
        wait_empty(50);
        btn = 3'b000;
        repeat (DEB + 4) tick();

        // Random presses, glitches and non-one-hot vectors; long enough to wrap the counter
        ready_mode = 2;
        for (int p = 0; p < 400; p++) begin
            v       = 3'($urandom_range(1, 7));
            short_p = ($urandom_range(0, 3) == 0);
            len     = short_p ? $urandom_range(1, DEB - 1) : $urandom_range(DEB + 2, DEB + 12);
            if (!short_p) push_exp(v);
            btn = v;
            repeat (len) tick();
            btn = 3'b000;
            repeat ($urandom_range(DEB + 2, DEB + 8)) tick();
            wait_empty(100);
        end

        repeat (5) tick();
        chk("final_queue", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
